// File: rtl/flight_cmd_pkg.sv
// Shared definitions for the flight command controller.
// Holds the host opcode encoding, the ACK/NAK response bytes, the controller
// FSM state encoding and the timer widths for fast-simulation and real builds.
package flight_cmd_pkg;

    // Host opcodes carried on cmd
    typedef enum logic [7:0] {
        OpSetPtch   = 8'h02,
        OpSetRoll   = 8'h03,
        OpSetYaw    = 8'h04,
        OpSetThrst  = 8'h05,
        OpCalibrate = 8'h06,
        OpEmerLand  = 8'h07,
        OpMtrsOff   = 8'h08
    } opcode_e;

    // Response bytes returned to the host
    localparam logic [7:0] RespAck = 8'hA5;
    localparam logic [7:0] RespNak = 8'h5A;

    // Controller states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSpinup = 2'd1,
        StCal    = 2'd2,
        StResp   = 2'd3
    } state_e;

    // Timer widths: the timers run for 2^width clocks
    localparam int unsigned SpinupWidthFast = 9;
    localparam int unsigned SpinupWidthSlow = 25;
    localparam int unsigned WdogWidthFast   = 10;
    localparam int unsigned WdogWidthSlow   = 26;

    function automatic int unsigned spinup_width(input int unsigned fast_sim);
        return (fast_sim != 0) ? SpinupWidthFast : SpinupWidthSlow;
    endfunction

    function automatic int unsigned wdog_width(input int unsigned fast_sim);
        return (fast_sim != 0) ? WdogWidthFast : WdogWidthSlow;
    endfunction

endpackage

// File: rtl/flight_cmd_wdog.sv
// Command watchdog for the flight command controller.
// A free-running counter that restarts from zero whenever clr is high and
// wraps on its own after reaching terminal count, so expired pulses once every
// 2^WIDTH clocks while no clear arrives.
//   clk     : clock, posedge
//   rst     : asynchronous active-high reset
//   clr     : restart the count from zero
//   expired : high during the clock in which the counter sits at terminal count
module flight_cmd_wdog #(
    parameter int unsigned WIDTH = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = &cnt_q;

endmodule

// File: rtl/flight_cmd_ctrl.sv
// Flight command controller.
// Consumes decoded host commands, maintains the pitch/roll/yaw/thrust
// setpoints, runs the motor spin-up and inertial calibration sequence, returns
// an ACK/NAK byte per command and lands the craft when the host goes silent.
//   clk, rst                      : clock (posedge) and async active-high reset
//   cmd_rdy, cmd, data            : decoded host command
//   clr_cmd_rdy                   : one-clock pulse consuming the command
//   resp, send_resp, resp_sent    : response handshake with the transmitter
//   d_ptch, d_roll, d_yaw, thrst  : setpoints to the flight controller
//   strt_cal, inertial_cal        : calibration start pulse / calibration active
//   cal_done                      : calibration finished
//   motors_off                    : motors disabled
module flight_cmd_ctrl
    import flight_cmd_pkg::*;
#(
    parameter int unsigned FAST_SIM = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    input  logic               resp_sent,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               strt_cal,
    output logic               inertial_cal,
    input  logic               cal_done,
    output logic               motors_off
);

    localparam int unsigned SpinW = spinup_width(FAST_SIM);
    localparam int unsigned WdogW = wdog_width(FAST_SIM);

    state_e            state_q, state_d;
    logic [SpinW-1:0]  spin_q, spin_d;
    logic [15:0]       ptch_q, ptch_d;
    logic [15:0]       roll_q, roll_d;
    logic [15:0]       yaw_q, yaw_d;
    logic [8:0]        thrst_q, thrst_d;
    logic              motors_off_q, motors_off_d;
    logic              clr_cmd_rdy_q, clr_cmd_rdy_d;
    logic              send_resp_q, send_resp_d;
    logic [7:0]        resp_q, resp_d;
    logic              strt_cal_q, strt_cal_d;
    logic              inertial_cal_q, inertial_cal_d;

    logic              consume;
    logic              wdog_clr;
    logic              wdog_expired;

    flight_cmd_wdog #(
        .WIDTH (WdogW)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .expired (wdog_expired)
    );

    always_comb begin
        state_d        = state_q;
        spin_d         = spin_q;
        ptch_d         = ptch_q;
        roll_d         = roll_q;
        yaw_d          = yaw_q;
        thrst_d        = thrst_q;
        motors_off_d   = motors_off_q;
        resp_d         = resp_q;
        inertial_cal_d = inertial_cal_q;
        clr_cmd_rdy_d  = 1'b0;
        send_resp_d    = 1'b0;
        strt_cal_d     = 1'b0;
        consume        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_rdy) begin
                    consume       = 1'b1;
                    clr_cmd_rdy_d = 1'b1;
                    resp_d        = RespAck;
                    send_resp_d   = 1'b1;
                    state_d       = StResp;
                    case (cmd)
                        OpSetPtch:  ptch_d  = data;
                        OpSetRoll:  roll_d  = data;
                        OpSetYaw:   yaw_d   = data;
                        OpSetThrst: thrst_d = data[8:0];
                        OpEmerLand: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        OpMtrsOff: begin
                            motors_off_d = 1'b1;
                            thrst_d      = '0;
                        end
                        OpCalibrate: begin
                            // Response is deferred until calibration completes
                            motors_off_d = 1'b0;
                            thrst_d      = '0;
                            resp_d       = resp_q;
                            send_resp_d  = 1'b0;
                            spin_d       = '0;
                            state_d      = StSpinup;
                        end
                        default: resp_d = RespNak;
                    endcase
                end
            end
            StSpinup: begin
                spin_d = spin_q + SpinW'(1);
                if (&spin_q) begin
                    strt_cal_d     = 1'b1;
                    inertial_cal_d = 1'b1;
                    state_d        = StCal;
                end
            end
            StCal: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    resp_d         = RespAck;
                    send_resp_d    = 1'b1;
                    state_d        = StResp;
                end
            end
            StResp: begin
                if (resp_sent) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog is held cleared through the spin-up/calibration sequence
        wdog_clr = consume || (state_q == StSpinup) || (state_q == StCal);

        // Host silence: land without a response; a command consumed in the
        // same clock wins because it also clears the watchdog
        if (wdog_expired && !wdog_clr) begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            spin_q         <= '0;
            ptch_q         <= '0;
            roll_q         <= '0;
            yaw_q          <= '0;
            thrst_q        <= '0;
            motors_off_q   <= 1'b1;
            clr_cmd_rdy_q  <= 1'b0;
            send_resp_q    <= 1'b0;
            resp_q         <= 8'h00;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            spin_q         <= spin_d;
            ptch_q         <= ptch_d;
            roll_q         <= roll_d;
            yaw_q          <= yaw_d;
            thrst_q        <= thrst_d;
            motors_off_q   <= motors_off_d;
            clr_cmd_rdy_q  <= clr_cmd_rdy_d;
            send_resp_q    <= send_resp_d;
            resp_q         <= resp_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
        end
    end

    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;
    assign motors_off   = motors_off_q;
    assign clr_cmd_rdy  = clr_cmd_rdy_q;
    assign send_resp    = send_resp_q;
    assign resp         = resp_q;
    assign strt_cal     = strt_cal_q;
    assign inertial_cal = inertial_cal_q;

endmodule

// File: tb/tb_flight_cmd_ctrl.sv
// Self-checking bench for flight_cmd_ctrl (FAST_SIM=1).
module tb_flight_cmd_ctrl;

    localparam int SpinClks = 512;
    localparam int WdogClks = 1024;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cmd_rdy = 1'b0;
    logic [7:0]         cmd = 8'h00;
    logic [15:0]        data = 16'h0000;
    logic               clr_cmd_rdy;
    logic [7:0]         resp;
    logic               send_resp;
    logic               resp_sent = 1'b0;
    logic signed [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0]         thrst;
    logic               strt_cal, inertial_cal;
    logic               cal_done = 1'b0;
    logic               motors_off;

    flight_cmd_ctrl #(
        .FAST_SIM (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .resp_sent    (resp_sent),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .cal_done     (cal_done),
        .motors_off   (motors_off)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int sr_count = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (send_resp === 1'b1) sr_count = sr_count + 1;

    // Reference model of the host-visible registers
    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thrst;
    logic        m_motors;

    // Results captured by do_cmd
    bit          seen_clr, snap_send, clr_again, send_again, resp_held;
    int          consume_cyc;
    logic [57:0] snap_regs;
    logic [7:0]  snap_resp;

    function automatic logic [57:0] model_regs();
        return {m_ptch, m_roll, m_yaw, m_thrst, m_motors};
    endfunction

    function automatic logic [57:0] dut_regs();
        return {d_ptch, d_roll, d_yaw, thrst, motors_off};
    endfunction

    task automatic model_reset();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_motors = 1'b1;
    endtask

    task automatic model_land();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0;
    endtask

    // Returns 1 when the command is acknowledged
    task automatic model_cmd(input logic [7:0] op, input logic [15:0] dat, output bit ack);
        ack = 1'b1;
        if (op == 8'h02) m_ptch = dat;
        else if (op == 8'h03) m_roll = dat;
        else if (op == 8'h04) m_yaw = dat;
        else if (op == 8'h05) m_thrst = dat % 512;
        else if (op == 8'h06) begin m_motors = 1'b0; m_thrst = 0; end
        else if (op == 8'h07) model_land();
        else if (op == 8'h08) begin m_motors = 1'b1; m_thrst = 0; end
        else ack = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Presents one command (called at a negedge), captures the consume clock,
    // then optionally completes the response handshake after a random delay.
    task automatic do_cmd(input logic [7:0] op, input logic [15:0] dat, input bit want_resp);
        int n;
        int dly;
        cmd = op; data = dat; cmd_rdy = 1'b1;
        seen_clr = 0; n = 0;
        while (clr_cmd_rdy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        cmd_rdy = 1'b0;
        if (clr_cmd_rdy === 1'b1) begin
            seen_clr = 1; consume_cyc = cyc;
            snap_regs = dut_regs(); snap_send = send_resp; snap_resp = resp;
            resp_held = 1;
            @(negedge clk);
            clr_again = clr_cmd_rdy; send_again = send_resp;
            if (want_resp) begin
                dly = $urandom_range(0, 3);
                for (int i = 0; i < dly; i++) begin
                    @(negedge clk);
                    if (resp !== snap_resp) resp_held = 0;
                end
                resp_sent = 1'b1;
                @(negedge clk);
                resp_sent = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bit changed;
        int sr0;
        rst = 1'b0; #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        tests++;
        if (dut_regs() !== model_regs() || resp !== 8'h00 || send_resp !== 1'b0 ||
            clr_cmd_rdy !== 1'b0 || strt_cal !== 1'b0 || inertial_cal !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: regs=%h resp=%h got, regs=%h resp=00 required",
                     dut_regs(), resp, model_regs());
        end
        changed = 0; sr0 = sr_count;
        repeat (WdogClks + 80) begin
            @(negedge clk);
            if (dut_regs() !== model_regs() || strt_cal !== 1'b0 || inertial_cal !== 1'b0)
                changed = 1;
        end
        tests++;
        if (changed || sr_count != sr0) begin
            fails++;
            $display("FAIL idle_quiet: changed=%0d send_resp_pulses=%0d, required 0 and 0",
                     changed, sr_count - sr0);
        end
    endtask

    task automatic test_set_ptch();
        bit ack;
        model_cmd(8'h02, 16'h0100, ack);
        do_cmd(8'h02, 16'h0100, 1);
        tests++;
        if (!seen_clr) begin
            fails++; $display("FAIL ptch_consume: no clr_cmd_rdy, required pulse");
        end else begin
            tests++;
            if (snap_regs !== model_regs() || d_ptch !== 16'sh0100) begin
                fails++;
                $display("FAIL ptch_value: regs=%h got, %h required", snap_regs, model_regs());
            end
            tests++;
            if (clr_again !== 1'b0 || snap_send !== 1'b1 || send_again !== 1'b0) begin
                fails++;
                $display("FAIL ptch_pulses: clr2=%0d send=%0d send2=%0d, required 0 1 0",
                         clr_again, snap_send, send_again);
            end
            tests++;
            if (snap_resp !== 8'hA5 || !resp_held) begin
                fails++;
                $display("FAIL ptch_resp: resp=%h held=%0d, required a5 held=1",
                         snap_resp, resp_held);
            end
        end
    endtask

    task automatic test_set_thrst();
        bit ack;
        model_cmd(8'h05, 16'hFEFF, ack);
        do_cmd(8'h05, 16'hFEFF, 1);
        tests++;
        if (!seen_clr || snap_regs !== model_regs() || thrst !== 9'h0FF || snap_resp !== 8'hA5) begin
            fails++;
            $display("FAIL thrst_trunc: seen=%0d thrst=%h resp=%h, required thrst 0ff resp a5",
                     seen_clr, thrst, snap_resp);
        end
    endtask

    task automatic test_calibrate();
        bit ack;
        int n, sr0, hold;
        bit ok;
        for (int it = 0; it < 2; it++) begin
            model_cmd(8'h06, 16'($urandom), ack);
            do_cmd(8'h06, data, 0);
            tests++;
            if (!seen_clr || snap_regs !== model_regs() || snap_send !== 1'b0) begin
                fails++;
                $display("FAIL cal_start[%0d]: seen=%0d regs=%h send=%0d, required regs=%h send 0",
                         it, seen_clr, snap_regs, snap_send, model_regs());
            end
            n = 0;
            while (strt_cal !== 1'b1 && n < SpinClks + 50) begin @(negedge clk); n++; end
            tests++;
            if (strt_cal !== 1'b1 || cyc - consume_cyc != SpinClks || inertial_cal !== 1'b1) begin
                fails++;
                $display("FAIL cal_spinup[%0d]: strt_cal after %0d clks inertial=%0d, required %0d and 1",
                         it, cyc - consume_cyc, inertial_cal, SpinClks);
            end
            @(negedge clk);
            tests++;
            if (strt_cal !== 1'b0) begin
                fails++; $display("FAIL cal_strt_width[%0d]: strt_cal=%0d, required 0", it, strt_cal);
            end
            // First pass waits longer than the watchdog to show it is held off
            hold = (it == 0) ? WdogClks + 100 : $urandom_range(5, 40);
            ok = 1; sr0 = sr_count;
            repeat (hold) begin
                @(negedge clk);
                if (inertial_cal !== 1'b1 || dut_regs() !== model_regs()) ok = 0;
            end
            tests++;
            if (!ok || sr_count != sr0) begin
                fails++;
                $display("FAIL cal_wait[%0d]: stable=%0d pulses=%0d, required 1 and 0",
                         it, ok, sr_count - sr0);
            end
            cal_done = 1'b1;
            @(negedge clk);
            cal_done = 1'b0;
            tests++;
            if (send_resp !== 1'b1 || resp !== 8'hA5 || inertial_cal !== 1'b0) begin
                fails++;
                $display("FAIL cal_done[%0d]: send=%0d resp=%h inertial=%0d, required 1 a5 0",
                         it, send_resp, resp, inertial_cal);
            end
            resp_sent = 1'b1;
            @(negedge clk);
            resp_sent = 1'b0;
        end
    endtask

    task automatic test_watchdog();
        bit ack;
        int t0, sr0;
        model_cmd(8'h03, 16'hFF80, ack);
        do_cmd(8'h03, 16'hFF80, 1);
        model_cmd(8'h05, 16'h00FF, ack);
        do_cmd(8'h05, 16'h00FF, 1);
        t0 = consume_cyc; sr0 = sr_count;
        wait_cyc(t0 + WdogClks - 1);
        tests++;
        if (dut_regs() !== model_regs()) begin
            fails++;
            $display("FAIL wdog_early: regs=%h got, %h required", dut_regs(), model_regs());
        end
        model_land();
        wait_cyc(t0 + WdogClks);
        tests++;
        if (dut_regs() !== model_regs() || d_roll !== 16'sd0 || thrst !== 9'd0 || sr_count != sr0) begin
            fails++;
            $display("FAIL wdog_land: regs=%h pulses=%0d, required %h and 0",
                     dut_regs(), sr_count - sr0, model_regs());
        end
        // Present SET_YAW so it is sampled in the next expiry clock
        wait_cyc(t0 + 2 * WdogClks - 1);
        model_cmd(8'h04, 16'h0080, ack);
        do_cmd(8'h04, 16'h0080, 1);
        tests++;
        if (!seen_clr || consume_cyc != t0 + 2 * WdogClks || snap_regs !== model_regs() ||
            d_yaw !== 16'sh0080 || snap_resp !== 8'hA5) begin
            fails++;
            $display("FAIL wdog_cmd_wins: clk=%0d regs=%h resp=%h, required clk=%0d regs=%h a5",
                     consume_cyc - t0, snap_regs, snap_resp, 2 * WdogClks, model_regs());
        end
        t0 = consume_cyc;
        wait_cyc(t0 + WdogClks - 1);
        tests++;
        if (d_yaw !== 16'sh0080) begin
            fails++; $display("FAIL wdog_restart_early: d_yaw=%h, required 0080", d_yaw);
        end
        model_land();
        wait_cyc(t0 + WdogClks);
        tests++;
        if (dut_regs() !== model_regs()) begin
            fails++;
            $display("FAIL wdog_restart: regs=%h got, %h required", dut_regs(), model_regs());
        end
    endtask

    task automatic test_nak();
        bit ack;
        model_cmd(8'h02, 16'h1234, ack);
        do_cmd(8'h02, 16'h1234, 1);
        model_cmd(8'h11, 16'hBEEF, ack);
        do_cmd(8'h11, 16'hBEEF, 1);
        tests++;
        if (!seen_clr || snap_resp !== 8'h5A || snap_send !== 1'b1 ||
            snap_regs !== model_regs() || dut_regs() !== model_regs()) begin
            fails++;
            $display("FAIL nak: resp=%h send=%0d regs=%h, required 5a 1 regs=%h",
                     snap_resp, snap_send, dut_regs(), model_regs());
        end
    endtask

    task automatic test_back_to_back();
        bit ack;
        bit stray;
        int n;
        model_cmd(8'h02, 16'h0F0F, ack);
        cmd = 8'h02; data = 16'h0F0F; cmd_rdy = 1'b1;
        n = 0;
        while (clr_cmd_rdy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        // Second command waiting while the first is still in RESP
        cmd = 8'h03; data = 16'h7070;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (clr_cmd_rdy !== 1'b0) stray = 1;
        end
        tests++;
        if (stray || dut_regs() !== model_regs()) begin
            fails++;
            $display("FAIL b2b_ignore: stray_clr=%0d regs=%h, required 0 and %h",
                     stray, dut_regs(), model_regs());
        end
        model_cmd(8'h03, 16'h7070, ack);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
        n = 0;
        while (clr_cmd_rdy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        cmd_rdy = 1'b0;
        tests++;
        if (clr_cmd_rdy !== 1'b1 || dut_regs() !== model_regs() || resp !== 8'hA5) begin
            fails++;
            $display("FAIL b2b_second: clr=%0d regs=%h resp=%h, required 1 %h a5",
                     clr_cmd_rdy, dut_regs(), resp, model_regs());
        end
        @(negedge clk);
        resp_sent = 1'b1;
        @(negedge clk);
        resp_sent = 1'b0;
    endtask

    task automatic test_random();
        bit ack;
        logic [7:0]  op;
        logic [15:0] dat;
        logic [7:0]  ops [7];
        ops = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h00};
        for (int it = 0; it < 40; it++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 8'h00 && $urandom_range(0, 1) == 1) op = 8'($urandom_range(9, 255));
            dat = 16'($urandom);
            model_cmd(op, dat, ack);
            do_cmd(op, dat, 1);
            tests++;
            if (!seen_clr || snap_regs !== model_regs() || snap_resp !== (ack ? 8'hA5 : 8'h5A) ||
                snap_send !== 1'b1 || send_again !== 1'b0 || clr_again !== 1'b0 || !resp_held) begin
                fails++;
                $display("FAIL random[%0d] op=%h data=%h: regs=%h resp=%h send=%0d%0d clr2=%0d held=%0d, required regs=%h resp=%h",
                         it, op, dat, snap_regs, snap_resp, snap_send, send_again, clr_again,
                         resp_held, model_regs(), ack ? 8'hA5 : 8'h5A);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_seq();
        bit ack;
        bit ok;
        int n, sr0;
        for (int ph = 0; ph < 2; ph++) begin
            model_cmd(8'h02, 16'h0A0A, ack);
            do_cmd(8'h02, 16'h0A0A, 1);
            model_cmd(8'h06, 16'h0000, ack);
            do_cmd(8'h06, 16'h0000, 0);
            if (ph == 0) begin
                repeat (100) @(negedge clk);
            end else begin
                n = 0;
                while (strt_cal !== 1'b1 && n < SpinClks + 50) begin @(negedge clk); n++; end
                repeat (10) @(negedge clk);
            end
            rst = 1'b1;
            model_reset();
            #1;
            tests++;
            if (inertial_cal !== 1'b0 || dut_regs() !== model_regs() || send_resp !== 1'b0 ||
                resp !== 8'h00) begin
                fails++;
                $display("FAIL reset_mid[%0d]: inertial=%0d regs=%h resp=%h, required 0 %h 00",
                         ph, inertial_cal, dut_regs(), resp, model_regs());
            end
            @(negedge clk);
            rst = 1'b0;
            ok = 1; sr0 = sr_count;
            repeat (SpinClks + 20) begin
                @(negedge clk);
                if (strt_cal !== 1'b0 || inertial_cal !== 1'b0) ok = 0;
            end
            tests++;
            if (!ok || sr_count != sr0) begin
                fails++;
                $display("FAIL reset_abort[%0d]: quiet=%0d pulses=%0d, required 1 and 0",
                         ph, ok, sr_count - sr0);
            end
            model_cmd(8'h04, 16'h5555, ack);
            do_cmd(8'h04, 16'h5555, 1);
            tests++;
            if (!seen_clr || snap_regs !== model_regs() || snap_resp !== 8'hA5) begin
                fails++;
                $display("FAIL reset_idle[%0d]: seen=%0d regs=%h resp=%h, required 1 %h a5",
                         ph, seen_clr, snap_regs, snap_resp, model_regs());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_set_ptch();
        test_set_thrst();
        test_calibrate();
        test_watchdog();
        test_nak();
        test_back_to_back();
        test_random();
        test_reset_mid_seq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flight_cmd_ctrl.md
FLIGHT_CMD_CTRL -- requirements
Module: flight_cmd_ctrl

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1; when 1, spin-up timer is 2^9 clks and watchdog is 2^10 clks; when 0, spin-up is 2^25 clks and watchdog is 2^26 clks.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports cmd_rdy (in, 1), cmd (in, 8) and data (in, 16): decoded host command from the UART wrapper.
REQ-005 SHALL have port clr_cmd_rdy, output, 1 bit: one-clk pulse consuming the command.
REQ-006 SHALL have ports resp (out, 8), send_resp (out, 1) and resp_sent (in, 1): response handshake to the UART transmitter.
REQ-007 SHALL have ports d_ptch, d_roll and d_yaw (out, 16 each, signed), and thrst (out, 9 bits, unsigned): setpoints to the flight controller.
REQ-008 SHALL have ports strt_cal (out, 1), inertial_cal (out, 1), cal_done (in, 1) and motors_off (out, 1).

Function
REQ-009 SHALL decode opcodes 02 SET_PTCH, 03 SET_ROLL, 04 SET_YAW, 05 SET_THRST, 06 CALIBRATE, 07 EMER_LAND, 08 MTRS_OFF; ACK = 8'hA5, NAK = 8'h5A.
REQ-010 SHALL implement FSM states IDLE, SPINUP, CAL, RESP.
REQ-011 In IDLE with cmd_rdy=1, SHALL assert clr_cmd_rdy for exactly one clk.
REQ-012 For SET_PTCH, SET_ROLL and SET_YAW, SHALL load data into the target register, visible one clk after cmd_rdy is sampled.
REQ-013 For SET_THRST, SHALL load data[8:0] into thrst, with the same latency as REQ-012.
REQ-014 For EMER_LAND, SHALL clear d_ptch, d_roll, d_yaw and thrst in one clk and keep motors_off unchanged.
REQ-015 For MTRS_OFF, SHALL set motors_off=1 and clear thrst.
REQ-016 For opcodes 02, 03, 04, 05, 07 and 08, SHALL drive resp=A5, pulse send_resp for one clk and go to RESP.
REQ-017 For any other opcode, SHALL change no register, drive resp=5A, pulse send_resp and go to RESP.
REQ-018 For CALIBRATE: SHALL clear motors_off and thrst, then go to SPINUP.
REQ-019 SPINUP SHALL count the spin-up time; at terminal count it SHALL pulse strt_cal for one clk, set inertial_cal=1 and go to CAL.
REQ-020 In CAL, SHALL wait for cal_done=1; then it SHALL clear inertial_cal, drive resp=A5, pulse send_resp and go to RESP.
REQ-021 RESP SHALL hold resp stable and wait for resp_sent=1, then return to IDLE.
REQ-022 cmd_rdy SHALL be ignored outside IDLE and consumed only once the FSM returns to IDLE.
REQ-023 The watchdog SHALL clear on every consumed command and count otherwise, in every state except SPINUP and CAL.
REQ-024 On watchdog terminal count, SHALL perform the EMER_LAND register action (no response is sent) and restart the watchdog.
REQ-025 If the watchdog expires in the same clk that cmd_rdy is consumed, the command SHALL win and the watchdog SHALL clear.
REQ-026 Data width rule: 16-bit setpoints SHALL be passed through unmodified; thrst SHALL take data[8:0] only, and data[15:9] SHALL be ignored.
REQ-027 A second CALIBRATE issued while motors are already running SHALL repeat the full SPINUP/CAL sequence.

Reset
REQ-028 On rst, SHALL asynchronously set the FSM to IDLE and clear d_ptch, d_roll, d_yaw, thrst, strt_cal, inertial_cal, clr_cmd_rdy, send_resp, resp (8'h00) and both counters.
REQ-029 On rst, SHALL set motors_off=1.
REQ-030 Reset asserted mid-SPINUP or mid-CAL SHALL abort the sequence with no response and leave inertial_cal=0.

Structure
REQ-031 Opcode enum, ACK/NAK constants, FSM state enum and timer widths SHALL live in package flight_cmd_pkg.
REQ-032 The watchdog counter SHALL be a sub-module named flight_cmd_wdog, with ports clk, rst, clr and expired.
REQ-033 The spin-up counter SHALL be inline.

Verification
REQ-034 After reset, SHALL check motors_off=1 and all setpoints=0; with no commands for 2^10 clks (FAST_SIM=1), it SHALL check that nothing changes and that send_resp is never pulsed.
REQ-035 SET_PTCH 16'h0100 SHALL give d_ptch=16'h0100 one clk after cmd_rdy, one clr_cmd_rdy pulse and resp=A5.
REQ-036 SET_THRST 16'hFEFF SHALL give thrst=9'h0FF.
REQ-037 CALIBRATE SHALL give motors_off=0, strt_cal 2^9 clks later, and inertial_cal high until cal_done is forced, followed by A5.
REQ-038 After SET_ROLL 16'hFF80 and SET_THRST 16'h00FF, with no commands for 2^10 clks, d_roll and thrst SHALL read 0 with no send_resp pulse; a SET_YAW 16'h0080 issued in the expiry clk SHALL give d_yaw=16'h0080 with thrst unchanged.
REQ-039 Opcode 8'h11 SHALL give resp=5A with all registers unchanged; rst asserted mid-CAL SHALL give IDLE, inertial_cal=0 and motors_off=1.
